// File: rtl/btn_conditioner.sv
// btn_conditioner: debounces active-low buttons into clean levels plus press/release strobes.
// Define BTN_LONGPRESS_EN to add the o_Long hold strobe.
module btn_conditioner #(
  parameter int NUM_BTN     = 3,
  parameter int DEB_CYCLES  = 500000,
  parameter int LONG_CYCLES = 50000000
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NUM_BTN-1:0] i_Btn,
  output logic [NUM_BTN-1:0] o_Level,
  output logic [NUM_BTN-1:0] o_Press,
  output logic [NUM_BTN-1:0] o_Release,
  output logic [NUM_BTN-1:0] o_Long
);
  localparam int MAX_C = (DEB_CYCLES > LONG_CYCLES) ? DEB_CYCLES : LONG_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  typedef enum logic [1:0] {UP, FILT_DN, DOWN, FILT_UP} state_e;
  logic [NUM_BTN-1:0] s1_q, s2_q;
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= i_Btn;
      s2_q <= s1_q;
    end
  end
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    state_e           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d, prs_q, prs_d, rel_q, rel_d;
    always_ff @(posedge Clk) begin
      if (!Rst) begin
        st_q  <= UP;
        cnt_q <= '0;
        lvl_q <= 1'b1;
        prs_q <= 1'b0;
        rel_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
        prs_q <= prs_d;
        rel_q <= rel_d;
      end
    end
    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      prs_d = 1'b0;
      rel_d = 1'b0;
      case (st_q)
        UP: begin
          st_d  = s2_q[g] ? UP : FILT_DN;
          cnt_d = '0;
        end
        FILT_DN: begin
          if (s2_q[g]) st_d = UP;
          else if (cnt_q == DEB_LAST) begin
            st_d  = DOWN;
            lvl_d = 1'b0;
            prs_d = 1'b1;
          end else cnt_d = cnt_q + 1'b1;
        end
        DOWN: begin
          st_d  = s2_q[g] ? FILT_UP : DOWN;
          cnt_d = '0;
        end
        default: begin
          if (!s2_q[g]) st_d = DOWN;
          else if (cnt_q == DEB_LAST) begin
            st_d  = UP;
            lvl_d = 1'b1;
            rel_d = 1'b1;
          end else cnt_d = cnt_q + 1'b1;
        end
      endcase
    end
    assign o_Level[g]   = lvl_q;
    assign o_Press[g]   = prs_q;
    assign o_Release[g] = rel_q;
`ifdef BTN_LONGPRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CYCLES);
    logic [CNT_W-1:0] lng_q, lng_d;
    logic             held, lp_q, lp_d;
    // FILT_UP still counts as held so a release bounce cannot restart the hold.
    always_comb begin
      held  = (st_q == DOWN) || (st_q == FILT_UP);
      lng_d = !held ? '0 : (lng_q == LONG_SAT) ? lng_q : lng_q + 1'b1;
      lp_d  = held && (lng_q == LONG_LAST);
    end
    always_ff @(posedge Clk) begin
      if (!Rst) begin
        lng_q <= '0;
        lp_q  <= 1'b0;
      end else begin
        lng_q <= lng_d;
        lp_q  <= lp_d;
      end
    end
    assign o_Long[g] = lp_q;
`else
    assign o_Long[g] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: scoreboard bench; stimulus queues expected strobe events, a monitor pops and checks them.
module tb_btn_conditioner;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int LAT  = DEB + 3;
  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [2:0] i_Btn = 3'b000;
  logic [2:0] o_Level, o_Press, o_Release, o_Long;
  int         cyc = 0;
  int         nchk = 0;
  int         npass = 0;
  typedef struct {
    int         cyc;
    logic [2:0] p, r, l, lvl;
  } ev_t;
  ev_t q[$];

  btn_conditioner #(.NUM_BTN(3), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG)) dut (
    .Clk(Clk), .Rst(Rst), .i_Btn(i_Btn),
    .o_Level(o_Level), .o_Press(o_Press), .o_Release(o_Release), .o_Long(o_Long)
  );

  always #10 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", n, cyc, act, exp);
  endtask

  task automatic to_cyc(input int n);
    while (cyc < n) @(negedge Clk);
  endtask

  task automatic expect_ev(input int at, input logic [2:0] p, r, l, lvl);
    q.push_back('{cyc: at, p: p, r: r, l: l, lvl: lvl});
  endtask

  always @(negedge Clk) begin
    ev_t e;
    if (q.size() != 0 && cyc > q[0].cyc) begin
      e = q.pop_front();
      chk("missing_event", 32'(cyc), 32'(e.cyc));
    end
    if (|{o_Press, o_Release, o_Long}) begin
      if (q.size() == 0) chk("unexpected_strobe", {20'd0, o_Press, o_Release, o_Long, o_Level}, 32'd0);
      else begin
        e = q.pop_front();
        chk("event_cycle", 32'(cyc), 32'(e.cyc));
        chk("event_value", {20'd0, o_Press, o_Release, o_Long, o_Level}, {20'd0, e.p, e.r, e.l, e.lvl});
      end
    end
  end

  initial begin
    for (int i = 1; i <= 3; i++) begin
      to_cyc(i);
      chk("reset_level", 32'(o_Level), 32'h7);
      chk("reset_strobes", {23'd0, o_Press, o_Release, o_Long}, 32'd0);
    end
    Rst = 1'b1;
    expect_ev(3 + LAT, 3'b111, 3'b000, 3'b000, 3'b000);
    to_cyc(12);
    i_Btn = 3'b111;
    expect_ev(12 + LAT, 3'b000, 3'b111, 3'b000, 3'b111);
    to_cyc(22);
    i_Btn = 3'b110;
    expect_ev(22 + LAT, 3'b001, 3'b000, 3'b000, 3'b110);
    to_cyc(32);
    i_Btn = 3'b111;
    expect_ev(32 + LAT, 3'b000, 3'b001, 3'b000, 3'b111);
    to_cyc(42);
    i_Btn = 3'b101;
    to_cyc(45);
    i_Btn = 3'b111;
    to_cyc(46);
    i_Btn = 3'b101;
    to_cyc(48);
    i_Btn = 3'b111;
    to_cyc(54);
    chk("bounce_level", 32'(o_Level), 32'h7);
    to_cyc(55);
    i_Btn = 3'b011;
    to_cyc(57);
    Rst = 1'b0;
    to_cyc(58);
    chk("midreset_level", 32'(o_Level), 32'h7);
    Rst = 1'b1;
    i_Btn = 3'b111;
    to_cyc(64);
    chk("after_reset_level", 32'(o_Level), 32'h7);
    to_cyc(65);
    i_Btn = 3'b110;
    expect_ev(65 + LAT, 3'b001, 3'b000, 3'b000, 3'b110);
`ifdef BTN_LONGPRESS_EN
    expect_ev(65 + LAT + LONG, 3'b000, 3'b000, 3'b001, 3'b110);
`endif
    to_cyc(105);
    i_Btn = 3'b111;
    expect_ev(105 + LAT, 3'b000, 3'b001, 3'b000, 3'b111);
    to_cyc(130);
    chk("final_level", 32'(o_Level), 32'h7);
    while (q.size() != 0) begin
      chk("event_never_seen", 32'(cyc), 32'(q[0].cyc));
      void'(q.pop_front());
    end
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
